fp16_mul_round_pack: RTL and testbench

Pipelined normalize/round/pack stage that sits directly downstream of the FP16 multiplier core. It consumes the raw 22-bit significand product, the signed unbiased exponent sum, and the result sign. It produces a correctly rounded IEEE-754 binary16 result (round-to-nearest-even) with exception and class flags. Special-operand results (NaN, infinity, zero) that the multiplier has already resolved pass through a bypass lane unmodified. Valid/ready handshake on both sides, latency 2 cycles, throughput 1 result per cycle.

---
 rtl/fp16_pkg.sv | 37 +++
 rtl/fp16_rne_round.sv | 38 +++
 rtl/fp16_mul_round_pack.sv | 155 +++++++++++++++
 tb/tb_fp16_mul_round_pack.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 constants and stage bundles for the FP16 round/pack path.
// Class and flag bit positions match the packed out_cls / out_flags buses.
package fp16_pkg;

  localparam logic signed [8:0] BIAS = 9'sd15;
  localparam logic [4:0] EXP_INF = 5'h1F;

  localparam int CLS_SNAN = 5;
  localparam int CLS_QNAN = 4;
  localparam int CLS_INF  = 3;
  localparam int CLS_ZERO = 2;
  localparam int CLS_SUB  = 1;
  localparam int CLS_NORM = 0;

  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  typedef struct packed {
    logic              sign;
    logic signed [8:0] exp_b;
    logic [10:0]       kept;
    logic              guard;
    logic              sticky;
    logic              tiny;
    logic              special;
    logic [15:0]       sp_val;
    logic [5:0]        sp_cls;
  } s1_t;

  function automatic logic [5:0] cls_bit(
    input int idx
  );
    return 6'b1 << idx;
  endfunction

endpackage

// File: rtl/fp16_rne_round.sv
// Round-to-nearest-even on kept/guard/sticky bits with exponent carry.
// Ports: kept,guard,sticky,exp_in -> sig,exp_out,carry,inexact.
module fp16_rne_round (
  input  logic              [10:0] kept,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed       [8:0]  exp_in,
  output logic              [9:0]  sig,
  output logic signed       [8:0]  exp_out,
  output logic                     carry,
  output logic                     inexact
);

  logic        inc;
  logic [11:0] sum;

  always_comb begin
    inc     = guard & (sticky | kept[0]);
    sum     = {1'b0, kept} + {11'b0, inc};
    carry   = sum[11];
    inexact = guard | sticky;
    sig     = carry ? sum[10:1] : sum[9:0];
    exp_out = exp_in;
    // A subnormal that rounds up to 1.0 x 2^-14 becomes min-normal.
    unique case (1'b1)
      carry: begin
        exp_out = exp_in + 9'sd1;
      end
      (exp_in == 9'sd0) && sum[10]: begin
        exp_out = 9'sd1;
      end
      default: begin
        exp_out = exp_in;
      end
    endcase
  end

endmodule

// File: rtl/fp16_mul_round_pack.sv
// Two-stage normalize / RNE round / pack stage behind the FP16 multiplier.
// Ports: in_* product + bypass with valid/ready, out_p/out_cls/out_flags.
module fp16_mul_round_pack
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [21:0] in_sig,
  input  logic        in_special,
  input  logic [15:0] in_special_val,
  input  logic [5:0]  in_special_cls,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic [5:0]  out_cls,
  output logic [2:0]  out_flags
);

  logic s1_valid;
  s1_t  s1_q;
  s1_t  s1_d;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = s2_adv;
  assign in_ready = !s1_valid | s1_adv;

  logic signed [8:0] e_unb;
  logic signed [8:0] e_bias;
  logic signed [8:0] sh_amt;
  logic        [4:0] sh;
  logic       [21:0] m;
  logic       [21:0] m_sh;
  logic       [43:0] ext;
  logic              sh_lost;
  logic              s1_tiny;
  logic              sig_zero;

  always_comb begin
    sig_zero = (in_sig == 22'h0);
    e_unb    = {in_exp[7], in_exp}
             + (in_sig[21] ? 9'sd1 : 9'sd0);
    m        = in_sig[21] ? in_sig
                          : {in_sig[20:0], 1'b0};
    e_bias   = e_unb + BIAS;
    s1_tiny  = (e_bias <= 9'sd0) && !sig_zero;
    sh_amt   = 9'sd1 - e_bias;
    sh       = 5'd0;
    // Shifts past the full width just fold everything into sticky.
    if (s1_tiny) begin
      sh = (sh_amt > 9'sd22) ? 5'd22 : sh_amt[4:0];
    end
    ext     = {m, 22'h0} >> sh;
    m_sh    = ext[43:22];
    sh_lost = |ext[21:0];

    s1_d         = '0;
    s1_d.sign    = in_sign;
    s1_d.exp_b   = (s1_tiny || sig_zero) ? 9'sd0 : e_bias;
    s1_d.kept    = m_sh[21:11];
    s1_d.guard   = m_sh[10];
    s1_d.sticky  = (|m_sh[9:0]) | sh_lost;
    s1_d.tiny    = s1_tiny;
    s1_d.special = in_special;
    s1_d.sp_val  = in_special_val;
    s1_d.sp_cls  = in_special_cls;
  end

  logic        [9:0] r_sig;
  logic signed [8:0] r_exp;
  logic              r_carry;
  logic              r_inx;

  fp16_rne_round u_rne (
    .kept    (s1_q.kept),
    .guard   (s1_q.guard),
    .sticky  (s1_q.sticky),
    .exp_in  (s1_q.exp_b),
    .sig     (r_sig),
    .exp_out (r_exp),
    .carry   (r_carry),
    .inexact (r_inx)
  );

  logic        ovf;
  logic [15:0] p_d;
  logic [5:0]  cls_d;
  logic [2:0]  flg_d;

  always_comb begin
    ovf = !s1_q.special
        && ((s1_q.exp_b >= 9'sd31)
         || (r_carry && (r_exp >= 9'sd31)));
    p_d   = '0;
    cls_d = '0;
    flg_d = '0;
    unique case (1'b1)
      s1_q.special: begin
        p_d   = s1_q.sp_val;
        cls_d = s1_q.sp_cls;
        flg_d = 3'b000;
      end
      ovf: begin
        p_d   = {s1_q.sign, EXP_INF, 10'h0};
        cls_d = cls_bit(CLS_INF);
        flg_d[FLG_OVF] = 1'b1;
        flg_d[FLG_INX] = 1'b1;
      end
      default: begin
        p_d = {s1_q.sign, r_exp[4:0], r_sig};
        if (r_exp != 9'sd0) begin
          cls_d = cls_bit(CLS_NORM);
        end else if (r_sig == 10'h0) begin
          cls_d = cls_bit(CLS_ZERO);
        end else begin
          cls_d = cls_bit(CLS_SUB);
        end
        flg_d[FLG_UNF] = s1_q.tiny & r_inx;
        flg_d[FLG_INX] = r_inx;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_cls   <= '0;
      out_flags <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_p     <= p_d;
          out_cls   <= cls_d;
          out_flags <= flg_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp16_mul_round_pack.sv
// Scoreboard bench for fp16_mul_round_pack with an exact-arithmetic
// binary16 reference model, random traffic and backpressure.
module tb_fp16_mul_round_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'h0;
  logic [21:0] in_sig = 22'h0;
  logic        in_special = 1'b0;
  logic [15:0] in_special_val = 16'h0;
  logic [5:0]  in_special_cls = 6'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_p;
  logic [5:0]  out_cls;
  logic [2:0]  out_flags;

  fp16_mul_round_pack dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_sig         (in_sig),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .in_special_cls (in_special_cls),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_p          (out_p),
    .out_cls        (out_cls),
    .out_flags      (out_flags)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] C_NORM = 6'b000001;
  localparam logic [5:0] C_SUB  = 6'b000010;
  localparam logic [5:0] C_ZERO = 6'b000100;
  localparam logic [5:0] C_INF  = 6'b001000;
  localparam logic [5:0] C_QNAN = 6'b010000;

  typedef struct packed {
    logic [15:0] p;
    logic [5:0]  c;
    logic [2:0]  f;
  } exp_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [21:0] sig;
    logic        special;
    logic [15:0] sv;
    logic [5:0]  sc;
    exp_t        x;
  } stim_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int total = 0;
  int bad = 0;
  int vprob = 100;
  int rdy_mode = 1;
  bit have = 1'b0;
  int n_out = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Exact value = sig * 2^(e-20); quantise to the binary16 grid.
  function automatic exp_t model(input logic s,
                                 input int e,
                                 input logic [21:0] sig);
    exp_t r;
    int msb, x, q, sh, be;
    longint unsigned n, rem, half;
    bit inx, tiny;
    r = '0;
    if (sig == 22'h0) begin
      r.p = {s, 15'h0};
      r.c = C_ZERO;
      r.f = 3'b000;
      return r;
    end
    msb = sig[21] ? 21 : 20;
    x = e - 20 + msb;
    q = (x - 10 > -24) ? x - 10 : -24;
    sh = q - (e - 20);
    if (sh >= 40) begin
      n = 0;
      rem = 1;
    end else begin
      n = 64'(sig) >> sh;
      rem = 64'(sig) & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && n[0]))
        n = n + 64'd1;
    end
    inx = (rem != 0);
    if (n == 64'd2048) begin
      n = 64'd1024;
      q = q + 1;
    end
    tiny = ((x + 15) <= 0);
    be = (n < 64'd1024) ? 0 : q + 25;
    if (be >= 31) begin
      r.p = {s, 5'h1F, 10'h0};
      r.c = C_INF;
      r.f = 3'b101;
    end else begin
      r.p = {s, 5'(be), 10'(n)};
      if (be != 0) r.c = C_NORM;
      else if (n == 0) r.c = C_ZERO;
      else r.c = C_SUB;
      r.f = {1'b0, tiny & inx, inx};
    end
    return r;
  endfunction

  task automatic push_dir(input logic s, input int e,
                          input logic [21:0] sig,
                          input logic [15:0] p,
                          input logic [5:0] c,
                          input logic [2:0] f);
    stim_t t;
    t = '0;
    t.sign = s;
    t.exp = 8'(e);
    t.sig = sig;
    t.x.p = p;
    t.x.c = c;
    t.x.f = f;
    stim_q.push_back(t);
  endtask

  task automatic push_spec(input logic [15:0] v,
                           input logic [5:0] c);
    stim_t t;
    t.sign = 1'($urandom);
    t.exp = 8'($urandom);
    t.sig = 22'($urandom);
    t.special = 1'b1;
    t.sv = v;
    t.sc = c;
    t.x.p = v;
    t.x.c = c;
    t.x.f = 3'b000;
    stim_q.push_back(t);
  endtask

  task automatic push_rand();
    stim_t t;
    int k, e;
    logic [31:0] r;
    logic [21:0] mk;
    k = int'($urandom_range(0, 99));
    if (k < 8) begin
      push_spec(16'($urandom),
                6'b1 << $urandom_range(0, 5));
    end else begin
      t = '0;
      t.sign = 1'($urandom);
      if (k < 22) e = int'($urandom_range(0, 30)) - 45;
      else e = int'($urandom_range(0, 60)) - 30;
      r = $urandom;
      if (k < 26) t.sig = 22'h0;
      else if (r[31]) t.sig = {1'b1, r[20:0]};
      else t.sig = {2'b01, r[19:0]};
      if (r[30]) begin
        mk = 22'h3FFFFF;
        mk = mk << $urandom_range(8, 12);
        t.sig = t.sig & mk;
      end
      t.exp = 8'(e);
      t.x = model(t.sign, e, t.sig);
      stim_q.push_back(t);
    end
  endtask

  task automatic wait_drain(input string name,
                            input int limit);
    int cyc;
    cyc = 0;
    while ((stim_q.size() != 0 || have || exp_q.size() != 0)
           && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, 32'(cyc < limit), 32'd1);
    if (cyc >= limit) begin
      stim_q.delete();
      exp_q.delete();
    end
  endtask

  // driver: holds each item until accepted
  initial begin
    stim_t cur;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!have && stim_q.size() != 0) begin
        cur = stim_q.pop_front();
        have = 1'b1;
      end
      if (have && int'($urandom_range(0, 99)) < vprob) begin
        in_valid = 1'b1;
        in_sign = cur.sign;
        in_exp = cur.exp;
        in_sig = cur.sig;
        in_special = cur.special;
        in_special_val = cur.sv;
        in_special_cls = cur.sc;
      end else begin
        in_valid = 1'b0;
      end
      #2;
      if (in_valid && in_ready && rst_n) begin
        exp_q.push_back(cur.x);
        have = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rdy_mode == 0)
        out_ready = ($urandom_range(0, 99) < 70);
      else
        out_ready = (rdy_mode == 1);
    end
  end

  // monitor: pops on each output transfer, checks held outputs
  initial begin
    bit held;
    exp_t hx, e;
    held = 1'b0;
    hx = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && held)
        chk("stall_hold",
            {7'h0, out_valid, out_p, out_cls, out_flags},
            {7'h0, 1'b1, hx.p, hx.c, hx.f});
      held = 1'b0;
      if (rst_n && out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("p#%0d", n_out),
                32'(out_p), 32'(e.p));
            chk($sformatf("cls#%0d", n_out),
                32'(out_cls), 32'(e.c));
            chk($sformatf("flags#%0d", n_out),
                32'(out_flags), 32'(e.f));
            chk($sformatf("onehot#%0d", n_out),
                32'($countones(out_cls)), 32'd1);
            n_out++;
          end
        end else begin
          held = 1'b1;
          hx.p = out_p;
          hx.c = out_cls;
          hx.f = out_flags;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_out_cls", 32'(out_cls), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    push_dir(0, 0, 22'h100000, 16'h3C00, C_NORM, 3'b000);
    push_dir(0, 0, 22'h240000, 16'h4080, C_NORM, 3'b000);
    push_dir(0, 0, 22'h100200, 16'h3C00, C_NORM, 3'b001);
    push_dir(0, 0, 22'h100600, 16'h3C02, C_NORM, 3'b001);
    push_dir(0, 15, 22'h240000, 16'h7C00, C_INF, 3'b101);
    push_dir(1, 15, 22'h240000, 16'hFC00, C_INF, 3'b101);
    push_dir(0, 14, 22'h3FFFFF, 16'h7C00, C_INF, 3'b101);
    push_dir(0, 14, 22'h100000, 16'h7400, C_NORM, 3'b000);
    push_dir(0, -15, 22'h100000, 16'h0200, C_SUB, 3'b000);
    push_dir(0, -40, 22'h100000, 16'h0000, C_ZERO, 3'b011);
    push_dir(0, -16, 22'h3FFFFF, 16'h0400, C_NORM, 3'b011);
    push_dir(0, -15, 22'h3FFFFF, 16'h0800, C_NORM, 3'b001);
    push_dir(0, -24, 22'h100000, 16'h0001, C_SUB, 3'b000);
    push_dir(0, -25, 22'h100000, 16'h0000, C_ZERO, 3'b011);
    push_dir(1, 5, 22'h000000, 16'h8000, C_ZERO, 3'b000);
    wait_drain("drain_directed", 200);

    push_spec(16'h7E00, C_QNAN);
    push_dir(0, 0, 22'h240000, 16'h4080, C_NORM, 3'b000);
    push_spec(16'h7E00, C_QNAN);
    push_spec(16'hFC00, C_INF);
    push_dir(1, 0, 22'h100000, 16'hBC00, C_NORM, 3'b000);
    push_spec(16'h8000, C_ZERO);
    wait_drain("drain_bypass", 200);

    vprob = 70;
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) push_rand();
    wait_drain("drain_random", 5000);

    vprob = 100;
    rdy_mode = 1;
    @(negedge clk);
    for (int i = 0; i < 40; i++) push_rand();
    cyc = 0;
    while ((stim_q.size() != 0 || have || exp_q.size() != 0)
           && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("throughput", 32'(cyc <= 46), 32'd1);
    wait_drain("drain_tput", 200);

    for (int i = 0; i < 5; i++) push_rand();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      rdy_mode = (c >= 3 && c <= 6) ? 2 : 1;
      #3;
      if (c == 6) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
      end
    end
    wait_drain("drain_bp", 200);

    rdy_mode = 2;
    push_dir(0, 0, 22'h100000, 16'h3C00, C_NORM, 3'b000);
    push_dir(0, 1, 22'h100000, 16'h4000, C_NORM, 3'b000);
    cyc = 0;
    while (!(stim_q.size() == 0 && !have && out_valid && !in_ready)
           && cyc < 50) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    chk("stall_full", 32'(cyc < 50), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    #3;
    chk("postrst_out_valid", 32'(out_valid), 32'd0);

    push_dir(0, -14, 22'h100000, 16'h0400, C_NORM, 3'b000);
    push_spec(16'h7E00, C_QNAN);
    for (int i = 0; i < 20; i++) push_rand();
    wait_drain("drain_final", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
